// File: rtl/tone_pkg.sv
// tone_pkg: shared note definitions for the tone path.
//   - NS note codes (NOTE_REST, NOTE_C4 .. NOTE_B4)
//   - nominal 12 MHz half-cycle-free period table (clk cycles per tone period),
//     also the divisor source for the clock divider
//   - 13 classification boundaries derived from that table
//   - FSM state enum for tone_note_detector
//   - classify(): period (clk cycles) -> NS note code
package tone_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_CS4  = 4'd2;
    localparam logic [3:0] NOTE_D4   = 4'd3;
    localparam logic [3:0] NOTE_DS4  = 4'd4;
    localparam logic [3:0] NOTE_E4   = 4'd5;
    localparam logic [3:0] NOTE_F4   = 4'd6;
    localparam logic [3:0] NOTE_FS4  = 4'd7;
    localparam logic [3:0] NOTE_G4   = 4'd8;
    localparam logic [3:0] NOTE_GS4  = 4'd9;
    localparam logic [3:0] NOTE_A4   = 4'd10;
    localparam logic [3:0] NOTE_AS4  = 4'd11;
    localparam logic [3:0] NOTE_B4   = 4'd12;

    localparam int unsigned NUM_NOTES = 12;

    // Index i holds the period of note code i+1 (C4 first, B4 last).
    localparam int unsigned NOTE_PERIOD [NUM_NOTES] = '{
        45867, 43293, 40863, 38569, 36405, 34362,
        32433, 30613, 28894, 27273, 25742, 24297
    };

    // BOUND[0] is C4+3% (inclusive upper limit), BOUND[12] is B4-3% rounded up
    // (inclusive lower limit); BOUND[1..11] are floor midpoints between
    // neighbours. A period equal to a midpoint belongs to the shorter note.
    localparam int unsigned NOTE_BOUND [NUM_NOTES+1] = '{
        (NOTE_PERIOD[0] * 103) / 100,
        (NOTE_PERIOD[0]  + NOTE_PERIOD[1])  / 2,
        (NOTE_PERIOD[1]  + NOTE_PERIOD[2])  / 2,
        (NOTE_PERIOD[2]  + NOTE_PERIOD[3])  / 2,
        (NOTE_PERIOD[3]  + NOTE_PERIOD[4])  / 2,
        (NOTE_PERIOD[4]  + NOTE_PERIOD[5])  / 2,
        (NOTE_PERIOD[5]  + NOTE_PERIOD[6])  / 2,
        (NOTE_PERIOD[6]  + NOTE_PERIOD[7])  / 2,
        (NOTE_PERIOD[7]  + NOTE_PERIOD[8])  / 2,
        (NOTE_PERIOD[8]  + NOTE_PERIOD[9])  / 2,
        (NOTE_PERIOD[9]  + NOTE_PERIOD[10]) / 2,
        (NOTE_PERIOD[10] + NOTE_PERIOD[11]) / 2,
        (NOTE_PERIOD[11] * 97 + 99) / 100
    };

    typedef enum logic {
        S_IDLE,
        S_COUNT
    } state_t;

    // Boundaries decrease monotonically, so the number of midpoints the
    // period exceeds is the distance from B4 towards C4.
    function automatic logic [3:0] classify(input int unsigned p);
        int unsigned above;
        logic [3:0]  code;
        code  = NOTE_REST;
        above = 0;
        if (p <= NOTE_BOUND[0] && p >= NOTE_BOUND[NUM_NOTES]) begin
            for (int unsigned i = 1; i < NUM_NOTES; i++) begin
                if (p > NOTE_BOUND[i]) above++;
            end
            code = NOTE_B4 - 4'(above);
        end
        return code;
    endfunction

endpackage

// File: rtl/tone_note_detector_edge_sync.sv
// edge_sync: 2-flop synchroniser followed by a registered rising-edge detect.
//   clk       system clock
//   rst       synchronous active-high reset
//   async_sig asynchronous input from a pin
//   rise      one-cycle pulse, high 3 clk cycles after a rising pin transition
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_sig,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta   <= async_sig;
            sync   <= meta;
            sync_d <= sync;
            rise   <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/tone_note_detector.sv
// tone_note_detector: measures the period of an incoming square wave and
// decodes it to the NS note code used by the buzzer clock divider.
//   clk          system clock (12 MHz)
//   rst          synchronous active-high reset
//   tone_in      asynchronous square wave
//   note         decoded NS code, 0 = silence/out of range, 1..12 = C4..B4
//   note_valid   high while note is 1..12
//   note_change  one-cycle pulse whenever note changes
//   period       last accepted period in clk cycles
// Optional build macro GLITCH_FILTER_EN: edges arriving before MIN_PERIOD
// cycles are ignored and the period keeps accumulating.
// PERIOD_SHIFT scales the raw count by 2**PERIOD_SHIFT before classification,
// for a prescaled tone source; 0 for a direct pin.
module tone_note_detector
    import tone_pkg::*;
#(
    parameter int unsigned CNT_W        = 17,
    parameter int unsigned TIMEOUT      = 60000,
    parameter int unsigned STABLE_N     = 4,
    parameter int unsigned MIN_PERIOD   = 20000,
    parameter int unsigned PERIOD_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    output logic [3:0]       note,
    output logic             note_valid,
    output logic             note_change,
    output logic [CNT_W-1:0] period
);

`ifdef GLITCH_FILTER_EN
    localparam bit GLITCH_ON = 1'b1;
`else
    localparam bit GLITCH_ON = 1'b0;
`endif

    localparam int unsigned      SW        = $clog2(STABLE_N + 1);
    localparam logic [SW-1:0]    STAB_MAX  = SW'(STABLE_N);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);

    state_t            state, state_n;
    logic [CNT_W-1:0]  counter, counter_n;
    logic [CNT_W-1:0]  period_n;
    logic [3:0]        cand, cand_n;
    logic [SW-1:0]     stab, stab_n;
    logic [3:0]        note_n;
    logic              valid_n;
    logic              change_n;
    logic              edge_pulse;
    logic              glitch;
    logic              measure;
    logic              expire;
    logic [3:0]        cls;

    edge_sync u_edge_sync (
        .clk       (clk),
        .rst       (rst),
        .async_sig (tone_in),
        .rise      (edge_pulse)
    );

    assign glitch = GLITCH_ON && (counter < MIN_C);
    assign cls    = classify(32'(counter) << PERIOD_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            counter     <= '0;
            period      <= '0;
            cand        <= NOTE_REST;
            stab        <= '0;
            note        <= NOTE_REST;
            note_valid  <= 1'b0;
            note_change <= 1'b0;
        end else begin
            state       <= state_n;
            counter     <= counter_n;
            period      <= period_n;
            cand        <= cand_n;
            stab        <= stab_n;
            note        <= note_n;
            note_valid  <= valid_n;
            note_change <= change_n;
        end
    end

    // Edge is tested before the timeout so a simultaneous edge is measured.
    always_comb begin
        state_n   = state;
        counter_n = counter;
        measure   = 1'b0;
        expire    = 1'b0;
        unique case (state)
            S_IDLE: begin
                counter_n = '0;
                if (edge_pulse) begin
                    counter_n = CNT_W'(1);
                    state_n   = S_COUNT;
                end
            end
            S_COUNT: begin
                if (edge_pulse && !glitch) begin
                    measure   = 1'b1;
                    counter_n = CNT_W'(1);
                end else if (counter == TIMEOUT_C) begin
                    expire    = 1'b1;
                    counter_n = '0;
                    state_n   = S_IDLE;
                end else begin
                    counter_n = counter + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        period_n = period;
        cand_n   = cand;
        stab_n   = stab;
        note_n   = note;
        valid_n  = note_valid;
        change_n = 1'b0;
        if (measure) begin
            period_n = counter;
            if (cls == cand) begin
                if (stab != STAB_MAX) stab_n = stab + 1'b1;
            end else begin
                cand_n = cls;
                stab_n = SW'(1);
            end
            // Once saturated cand already equals note, so no repeat pulses.
            if (stab_n == STAB_MAX && cand_n != note) begin
                note_n   = cand_n;
                valid_n  = (cand_n != NOTE_REST);
                change_n = 1'b1;
            end
        end else if (expire) begin
            cand_n = NOTE_REST;
            stab_n = '0;
            if (note != NOTE_REST) begin
                note_n   = NOTE_REST;
                valid_n  = 1'b0;
                change_n = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tone_note_detector.sv
module tb_tone_note_detector;

    localparam int unsigned CNT_W    = 17;
    localparam int unsigned TIMEOUT  = 1000;
    localparam int unsigned STABLE_N = 4;
    localparam int unsigned MIN_P    = 312;
    localparam int unsigned SHIFT    = 6;
`ifdef GLITCH_FILTER_EN
    localparam bit          GLITCH   = 1'b1;
    localparam int unsigned R4_PER   = 312;
`else
    localparam bit          GLITCH   = 1'b0;
    localparam int unsigned R4_PER   = 150;
`endif

    localparam int unsigned NOM [12] = '{
        45867, 43293, 40863, 38569, 36405, 34362,
        32433, 30613, 28894, 27273, 25742, 24297
    };

    logic             clk = 1'b0;
    logic             rst;
    logic             tone_in;
    logic [3:0]       note;
    logic             note_valid;
    logic             note_change;
    logic [CNT_W-1:0] period;

    always #5 clk = ~clk;

    tone_note_detector #(
        .CNT_W        (CNT_W),
        .TIMEOUT      (TIMEOUT),
        .STABLE_N     (STABLE_N),
        .MIN_PERIOD   (MIN_P),
        .PERIOD_SHIFT (SHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tone_in     (tone_in),
        .note        (note),
        .note_valid  (note_valid),
        .note_change (note_change),
        .period      (period)
    );

    typedef struct {
        int unsigned due;
        int unsigned per;
        int unsigned nt;
        bit          vld;
        bit          chg;
    } exp_t;

    typedef struct {
        int          op;     // 0 tone, 1 hold low, 2 reset pulse
        int unsigned p;
        int unsigned n;
        int unsigned nt;
        bit          vld;
        int unsigned per;
        int unsigned chg;
    } row_t;

    exp_t        sbq[$];
    exp_t        sb_e;
    row_t        rows[12];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned dut_chg = 0;

    bit          m_idle = 1'b1;
    int unsigned m_last = 0;
    int unsigned m_cand = 0;
    int unsigned m_stab = 0;
    int unsigned m_note = 0;
    int unsigned m_per  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Nearest nominal note; ties go to the shorter period.
    function automatic int unsigned ref_class(input int unsigned p);
        int unsigned best, bestd, d;
        if (p * 100 > NOM[0] * 103 || p * 100 < NOM[11] * 97) return 0;
        best  = 0;
        bestd = 32'hFFFF_FFFF;
        for (int i = 0; i < 12; i++) begin
            d = (p > NOM[i]) ? p - NOM[i] : NOM[i] - p;
            if (d <= bestd) begin
                bestd = d;
                best  = i + 1;
            end
        end
        return best;
    endfunction

    always @(negedge clk) begin
        if (note_change === 1'b1) dut_chg++;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            sb_e = sbq.pop_front();
            chk("sb_due",    cyc, sb_e.due);
            chk("sb_period", period, sb_e.per);
            chk("sb_note",   note, sb_e.nt);
            chk("sb_valid",  note_valid, sb_e.vld);
            chk("sb_change", note_change, sb_e.chg);
        end
    end

    task automatic wait_cycles(input int unsigned k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic model_rise(input int unsigned c);
        exp_t        e;
        int unsigned p, k;
        e.due = c + 4;
        e.chg = 1'b0;
        if (m_idle) begin
            m_idle = 1'b0;
            m_last = c;
        end else begin
            p = c - m_last;
            if (!(GLITCH && p < MIN_P)) begin
                m_last = c;
                m_per  = p;
                k      = ref_class(p << SHIFT);
                if (k == m_cand) begin
                    if (m_stab < STABLE_N) m_stab++;
                end else begin
                    m_cand = k;
                    m_stab = 1;
                end
                if (m_stab == STABLE_N && m_cand != m_note) begin
                    m_note = m_cand;
                    e.chg  = 1'b1;
                end
            end
        end
        e.per = m_per;
        e.nt  = m_note;
        e.vld = (m_note != 0);
        sbq.push_back(e);
    endtask

    task automatic tone(input int unsigned p, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            tone_in = 1'b1;
            model_rise(cyc);
            wait_cycles(p / 2);
            tone_in = 1'b0;
            wait_cycles(p - p / 2);
        end
    endtask

    task automatic hold_low(input int unsigned n);
        exp_t e;
        if (!m_idle) begin
            e.due = m_last + 4 + TIMEOUT - 1;
            e.per = m_per;
            e.nt  = m_note;
            e.vld = (m_note != 0);
            e.chg = 1'b0;
            sbq.push_back(e);
            e.due = e.due + 1;
            e.chg = (m_note != 0);
            e.nt  = 0;
            e.vld = 1'b0;
            sbq.push_back(e);
            m_idle = 1'b1;
            m_cand = 0;
            m_stab = 0;
            m_note = 0;
        end
        wait_cycles(n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned chg0;
        //          op  p     n  note vld per     chg
        rows[0]  = '{0, 426,  6, 10,  1,  426,    1};
        rows[1]  = '{0, 716,  5, 1,   1,  716,    1};
        rows[2]  = '{1, 1100, 0, 0,   0,  716,    1};
        rows[3]  = '{0, 312,  6, 0,   0,  312,    0};
        rows[4]  = '{0, 150,  2, 0,   0,  R4_PER, 0};
        rows[5]  = '{1, 1100, 0, 0,   0,  R4_PER, 0};
        rows[6]  = '{0, 380,  5, 12,  1,  380,    1};
        rows[7]  = '{0, 716,  2, 12,  1,  716,    0};
        rows[8]  = '{2, 200,  0, 0,   0,  0,      0};
        rows[9]  = '{0, 716,  5, 1,   1,  716,    1};
        rows[10] = '{0, 1000, 2, 1,   1,  1000,   0};
        rows[11] = '{1, 1100, 0, 0,   0,  1000,   1};

        rst     = 1'b1;
        tone_in = 1'b0;
        wait_cycles(1);
        for (int i = 0; i < 5; i++) begin
            tone_in = ~tone_in;
            wait_cycles(1);
            chk("rst_note",   note, 0);
            chk("rst_valid",  note_valid, 0);
            chk("rst_change", note_change, 0);
            chk("rst_period", period, 0);
        end
        tone_in = 1'b0;
        rst     = 1'b0;
        wait_cycles(1);
        chk("rel_note",   note, 0);
        chk("rel_valid",  note_valid, 0);
        chk("rel_change", note_change, 0);
        chk("rel_period", period, 0);

        for (int i = 0; i < 12; i++) begin
            chg0 = dut_chg;
            case (rows[i].op)
                0: tone(rows[i].p, rows[i].n);
                1: hold_low(rows[i].p);
                default: begin
                    wait_cycles(rows[i].p);
                    rst = 1'b1;
                    wait_cycles(1);
                    chk("midrst_note",   note, 0);
                    chk("midrst_valid",  note_valid, 0);
                    chk("midrst_change", note_change, 0);
                    chk("midrst_period", period, 0);
                    rst    = 1'b0;
                    m_idle = 1'b1;
                    m_cand = 0;
                    m_stab = 0;
                    m_note = 0;
                    m_per  = 0;
                end
            endcase
            chk($sformatf("row%0d_note", i),    note, rows[i].nt);
            chk($sformatf("row%0d_valid", i),   note_valid, rows[i].vld);
            chk($sformatf("row%0d_period", i),  period, rows[i].per);
            chk($sformatf("row%0d_changes", i), dut_chg - chg0, rows[i].chg);
        end

        wait_cycles(10);
        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tone_note_detector.md
Name: tone_note_detector

Overview:
- Inverse of the buzzer tone path: measures the period of an incoming square wave and decodes it to the same 4-bit note code (NS) that drives the clock divider.
- Used for loopback self-test of the buzzer output, and for a "play-back what you hear" mode fed from a comparator on a PMOD pin.
- Sits beside beat_scheduler. Its note/note_valid outputs are NS-compatible.

Parameters:
- CNT_W, 17, width of period counter and period output
- TIMEOUT, 60000, cycles without a rising edge before the tone is declared absent
- STABLE_N, 4, consecutive identical classifications required before the note output updates
- MIN_PERIOD, 20000, shortest period accepted as a real edge (used only with GLITCH_FILTER_EN)

Ports:
- clk  input  1  system clock, 12 MHz
- rst  input  1  synchronous, active-high reset
- tone_in  input  1  asynchronous square wave from the pin
- note  output  4  decoded NS code: 0 = silence/out-of-range, 1..12 = C4..B4
- note_valid  output  1  high while note is a valid 1..12 code
- note_change  output  1  one-cycle pulse whenever note changes
- period  output  CNT_W  last accepted period, in clk cycles

Behaviour:
- Reset: note=0, note_valid=0, note_change=0, period=0. Synchroniser, counter, candidate and stability count all cleared; FSM goes to S_IDLE.
- Input path: 2-flop synchroniser, then a registered rising-edge detect. edge_pulse is high 3 clk cycles after the pin transition.
- FSM, S_IDLE: counter held at 0. On edge_pulse: counter=1, go to S_COUNT. No classification is made on the first edge.
- FSM, S_COUNT: counter increments each cycle.
  - On edge_pulse: measured period = counter, i.e. the cycle count between edges. Then counter=1.
  - If counter reaches TIMEOUT with no edge: go to S_IDLE. Clear candidate and count. If note != 0, set note=0 and note_valid=0, and pulse note_change.
- Classification is combinational on the measured period, against boundaries from the package table (12 MHz nominal periods, C4=45867 down to B4=24297). Boundaries are the integer midpoints between adjacent notes; the outer edges are C4+3% and B4-3%. A period outside the outer edges gives code 0.
- period is updated, and classification registered, in the cycle after edge_pulse.
- Stability logic:
  - If class == cand: cnt = min(cnt+1, STABLE_N).
  - Otherwise: cand = class, cnt = 1.
  - In the cycle cnt becomes STABLE_N with cand != note: note = cand, note_valid = (cand != 0), note_change = 1 for exactly that cycle.
  - While cnt stays saturated, no further pulses.
- Simultaneous edge_pulse and counter==TIMEOUT: the edge wins and is measured normally.
- rst has priority over everything. Asserting it mid-measurement gives reset values on the following cycle, with no note_change pulse.

Optional Feature:
- GLITCH_FILTER_EN defined: an edge_pulse with counter < MIN_PERIOD is ignored. The counter keeps counting, period is not updated, and there is no classification. Ringing and bounce are absorbed.
- Not defined: every edge is measured. Short periods classify as 0 and disturb stability.

Decomposition:
- Package tone_pkg holds:
  - the NS code localparams (NOTE_REST=0, NOTE_C4=1 .. NOTE_B4=12)
  - the nominal 12 MHz period table
  - the 13 derived classification boundaries
  - the FSM state enum.
  The clk_divider divisor table is refactored to share it.
- One sub-module, edge_sync: 2-flop synchroniser plus rising-edge pulse, reusable for the P2_9 button path.

Test Plan:
- Reset: hold rst 5 cycles with tone_in toggling -> note=0, note_valid=0, note_change=0, period=0 throughout, and on the cycle after release.
- A4 lock: square wave with period 27273 cycles, 6 periods -> period=27273 after the 2nd edge; note=10 and note_valid=1 after the 5th rising edge (4th measurement); exactly one note_change pulse.
- Note change: A4 locked, then switch to 45867-cycle period -> note stays 10 for 3 C4 measurements, becomes 1 on the 4th; one note_change pulse.
- Timeout: A4 locked, then hold tone_in low -> exactly 60000 cycles after the last edge_pulse, note=0 and note_valid=0 with one note_change pulse; a new tone relocks after 5 edges.
- Out of range: period 20000 for 6 periods -> note=0, note_valid=0, no note_change; with GLITCH_FILTER_EN, period 19999 gives no period update at all.
- Mid-run reset: assert rst for 1 cycle during a C4 measurement -> all outputs 0 on the next cycle; relock needs 5 fresh edges.
